// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 core front end: reset PC, IFU state encoding,
// and opcode constants also used by the decoder.
package ysyx_23060187_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

endpackage

// File: rtl/ysyx_23060187_ifu_pc.sv
// Program counter for the IFU: reset value, sequential +4 step and redirect target select,
// advanced only when decode accepts the current instruction.
module ysyx_23060187_ifu_pc #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Targets are forced word aligned so pc[1:0] can never become nonzero.
    assign w_pc_next = i_redirect_valid ? (i_redirect_pc & ALIGN_MASK) : (r_pc + XLEN'(4));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC & ALIGN_MASK;
        end else if (i_en) begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit: REQ/WAIT/HOLD fetch loop towards imem, valid/ready towards decode.
// Optional performance counters are built when YSYX_23060187_IFU_PERF_EN is defined.
module ysyx_23060187_ifu
    import ysyx_23060187_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    output logic            imem_resp_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      fun3,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_wait_cnt
);

    ifu_state_e      r_state;
    ifu_state_e      w_state_next;
    logic [31:0]     r_inst;
    logic            r_inst_fault;
    logic [XLEN-1:0] w_pc;
    logic            w_fire;
    logic            w_resp_take;

    assign w_fire      = (r_state == S_HOLD) && inst_ready;
    assign w_resp_take = (r_state == S_WAIT) && imem_resp_valid;

    ysyx_23060187_ifu_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk              (clk),
        .rst              (rst),
        .i_en             (w_fire),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_pc             (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_REQ;
            S_REQ:   if (imem_req_ready)  w_state_next = S_WAIT;
            S_WAIT:  if (imem_resp_valid) w_state_next = S_HOLD;
            S_HOLD:  if (inst_ready)      w_state_next = S_REQ;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst       <= '0;
            r_inst_fault <= 1'b0;
        end else if (w_resp_take) begin
            r_inst       <= imem_rdata;
            r_inst_fault <= imem_resp_err;
        end
    end

    // Handshake outputs depend on state alone, so no combinational path from memory or decode.
    assign imem_req_valid  = (r_state == S_REQ);
    assign imem_resp_ready = (r_state == S_WAIT);
    assign inst_valid      = (r_state == S_HOLD);
    assign imem_addr       = w_pc;
    assign inst_pc         = w_pc;
    assign inst            = r_inst;
    assign inst_fault      = r_inst_fault;
    assign opcode          = r_inst[6:0];
    assign fun3            = r_inst[14:12];

`ifdef YSYX_23060187_IFU_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch_cnt <= '0;
            r_perf_wait_cnt  <= '0;
        end else begin
            if (w_fire) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if ((r_state == S_WAIT) && !imem_resp_valid) begin
                r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_wait_cnt  = r_perf_wait_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_wait_cnt  = '0;
`endif

endmodule
